// File: rtl/ofm_pack_pkg.sv
`default_nettype none
// ofm_pack_pkg: shared types for the OFM byte packer and its word FIFO.
// Rev 1.0
package ofm_pack_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  strb;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/ofm_word_fifo.sv
`default_nettype none
// ofm_word_fifo: show-ahead synchronous FIFO; push is accepted when full if a pop happens.
// Rev 1.0
module ofm_word_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [35:0]
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being popped is the one the new entry lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wptr[PTR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ofm_pack_writer.sv
`default_nettype none
// ofm_pack_writer: packs PE OFM bytes little-endian into 32-bit words for the SRAM writer.
// Rev 1.0
module ofm_pack_writer
  import ofm_pack_pkg::*;
#(
  parameter int               ADDR_W     = 16,
  parameter int               FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] total_ofm,
  input  logic [7:0]        ofm_in,
  input  logic              ofm_valid,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LANES-1:0]  wr_strb,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int IDX_W = $clog2(LANES);

  state_t             state;
  state_t             state_nx;
  logic [ADDR_W-1:0]  total;
  logic [ADDR_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0]  word_idx;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  pack;
  logic               overflow_r;

  logic               start_ok;
  logic               accept;
  logic               last_byte;
  logic               word_done;
  logic               pop;
  logic               full;
  logic               empty;
  logic               fifo_push;
  logic [WORD_W-1:0]  word_data;
  logic [LANES-1:0]   word_strb;
  fifo_entry_t        in_entry;
  fifo_entry_t        head;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign accept    = (state == COLLECT) && ofm_valid;
  assign last_byte = (byte_cnt == (total - ADDR_W'(1)));
  assign word_done = accept && ((idx == IDX_W'(LANES - 1)) || last_byte);
  // Upper lanes of pack are already zero, so OR-ing in the current byte completes the word.
  assign word_data = pack | ({24'd0, ofm_in} << {idx, 3'b000});
  assign word_strb = LANES'((5'd2 << idx) - 5'd1);
  assign in_entry  = '{data: word_data, strb: word_strb};

  assign pop       = wr_valid && wr_ready;
  assign fifo_push = word_done && (!full || pop);

  ofm_word_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign wr_valid = !empty;
  assign wr_data  = empty ? '0 : head.data;
  assign wr_strb  = empty ? '0 : head.strb;
  assign wr_addr  = BASE_ADDR + word_idx;
  assign busy     = (state == COLLECT) || (state == DRAIN);
  assign done     = (state == DONE);
  assign overflow = overflow_r;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (total_ofm == '0) ? DONE : COLLECT;
      COLLECT:    if (accept && last_byte) state_nx = DRAIN;
      DRAIN:      if (empty) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total      <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      idx        <= '0;
      pack       <= '0;
      overflow_r <= 1'b0;
    end else if (start_ok) begin
      total      <= total_ofm;
      byte_cnt   <= '0;
      word_idx   <= '0;
      idx        <= '0;
      pack       <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (word_done) begin
          idx  <= '0;
          pack <= '0;
        end else begin
          idx  <= idx + 1'b1;
          pack <= word_data;
        end
      end
      // A completed word with nowhere to go is dropped; its address is not consumed.
      if (word_done && full && !pop) overflow_r <= 1'b1;
      if (pop) word_idx <= word_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire
